// File: rtl/timing_pkg.sv
// Shared encodings for the timing sequencer: T-state numbering and the
// interrupt vector select values.
package timing_pkg;

   typedef logic [2:0] tstate_t;

   localparam tstate_t TS_T0 = 3'd0;
   localparam tstate_t TS_T1 = 3'd1;
   localparam tstate_t TS_T2 = 3'd2;
   localparam tstate_t TS_T3 = 3'd3;
   localparam tstate_t TS_T4 = 3'd4;
   localparam tstate_t TS_T5 = 3'd5;
   localparam tstate_t TS_T6 = 3'd6;

   typedef logic [1:0] vecsel_t;

   localparam vecsel_t VEC_IRQ = 2'd0;
   localparam vecsel_t VEC_NMI = 2'd1;
   localparam vecsel_t VEC_RES = 2'd2;

endpackage

// File: rtl/nmi_latch.sv
// NMI falling-edge detector and pending latch. The edge detect runs every
// clock, stalled or not; only the clear is qualified by the caller.
module nmi_latch (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_nmi_n,
   input  logic i_clr,
   output logic o_nmip,
   output logic o_edge
);

   logic r_nmi_prev;
   logic r_nmip;
   logic w_edge;

   // Previous sample resets low so an NMI line already held low at reset
   // release is not mistaken for a fresh edge.
   assign w_edge = r_nmi_prev & ~i_nmi_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_nmi_prev <= 1'b0;
         r_nmip     <= 1'b0;
      end else begin
         r_nmi_prev <= i_nmi_n;
         r_nmip     <= w_edge | (r_nmip & ~i_clr);
      end
   end

   assign o_nmip = r_nmip;
   assign o_edge = w_edge;

endmodule

// File: rtl/timing_sequencer.sv
// 6502-style T-state sequencer with IRQ/NMI/BRK/reset sequencing and RDY stalls.
// Optional macro TSEQ_NMI_EN builds the NMI edge detect and latch.
module timing_sequencer
   import timing_pkg::*;
(
   input  logic       PHI0,
   input  logic       _RES,
   input  logic       RDY,
   input  logic       WR,
   input  logic       TWOCYCLE,
   input  logic       ENDX,
   input  logic       BRK_OP,
   input  logic       _IRQ,
   input  logic       _NMI,
   input  logic       I_FLAG,
   output logic       T0,
   output logic       T1,
   output logic       T2,
   output logic       T3,
   output logic       T4,
   output logic       T5,
   output logic       T6,
   output logic       SYNC,
   output logic       FORCE_BRK,
   output logic       INT_SEQ,
   output logic       RESP,
   output logic       BRK6E,
   output logic [1:0] VEC,
   output logic       _ready
);

   tstate_t r_tstate;
   tstate_t w_tstate_nxt;
   logic    r_int_seq;
   logic    w_int_seq_nxt;
   logic    r_force_brk;
   logic    w_force_brk_nxt;
   logic    r_resp;
   vecsel_t r_vec_frz;
   vecsel_t w_vec_live;
   vecsel_t w_vec_cap;
   logic    w_adv;
   logic    w_enter_t0;
   logic    w_int_pend;
   logic    w_nmip;
   logic    w_nmi_edge;
   logic    w_nmi_clr;

   assign w_adv      = RDY | WR;
   assign w_int_pend = w_nmip | (~_IRQ & ~I_FLAG);
   assign w_enter_t0 = (w_tstate_nxt == TS_T0);
   assign w_nmi_clr  = w_adv & w_enter_t0 & r_int_seq & (r_vec_frz == VEC_NMI);

`ifdef TSEQ_NMI_EN
   nmi_latch u_nmi_latch (
      .i_clk   (PHI0),
      .i_rst_n (_RES),
      .i_nmi_n (_NMI),
      .i_clr   (w_nmi_clr),
      .o_nmip  (w_nmip),
      .o_edge  (w_nmi_edge)
   );
`else
   logic w_unused_nmi;
   assign w_unused_nmi = _NMI ^ w_nmi_clr;
   assign w_nmip       = 1'b0;
   assign w_nmi_edge   = 1'b0;
`endif

   assign w_vec_live = r_resp ? VEC_RES : (w_nmip ? VEC_NMI : VEC_IRQ);
   // The frozen value includes an edge seen in T4 itself, so "by T4" hijacks.
   assign w_vec_cap  = r_resp ? VEC_RES : ((w_nmip | w_nmi_edge) ? VEC_NMI : VEC_IRQ);

   always_comb begin
      w_tstate_nxt    = r_tstate;
      w_int_seq_nxt   = r_int_seq;
      w_force_brk_nxt = r_force_brk;
      case (r_tstate)
         TS_T0: begin
            w_tstate_nxt = TS_T1;
            if (w_int_pend) begin
               w_int_seq_nxt   = 1'b1;
               w_force_brk_nxt = 1'b1;
            end
         end
         TS_T1: begin
            if (!r_int_seq && BRK_OP) begin
               w_tstate_nxt  = TS_T2;
               w_int_seq_nxt = 1'b1;
            end else if (!r_int_seq && TWOCYCLE) begin
               w_tstate_nxt = TS_T0;
            end else begin
               w_tstate_nxt = TS_T2;
            end
         end
         TS_T2, TS_T3, TS_T4, TS_T5: begin
            if (ENDX && !r_int_seq) w_tstate_nxt = TS_T0;
            else                    w_tstate_nxt = r_tstate + 3'd1;
         end
         default: w_tstate_nxt = TS_T0;
      endcase
      if (w_tstate_nxt == TS_T0) begin
         w_int_seq_nxt   = 1'b0;
         w_force_brk_nxt = 1'b0;
      end
   end

   always_ff @(posedge PHI0 or negedge _RES) begin
      if (!_RES) begin
         r_tstate    <= TS_T1;
         r_int_seq   <= 1'b1;
         r_force_brk <= 1'b1;
         r_resp      <= 1'b1;
         r_vec_frz   <= VEC_RES;
      end else if (w_adv) begin
         r_tstate    <= w_tstate_nxt;
         r_int_seq   <= w_int_seq_nxt;
         r_force_brk <= w_force_brk_nxt;
         r_resp      <= r_resp & ~w_enter_t0;
         if (r_tstate == TS_T4) r_vec_frz <= w_vec_cap;
      end
   end

   assign T0        = (r_tstate == TS_T0);
   assign T1        = (r_tstate == TS_T1);
   assign T2        = (r_tstate == TS_T2);
   assign T3        = (r_tstate == TS_T3);
   assign T4        = (r_tstate == TS_T4);
   assign T5        = (r_tstate == TS_T5);
   assign T6        = (r_tstate == TS_T6);
   assign SYNC      = T1 & ~r_int_seq;
   assign FORCE_BRK = r_force_brk;
   assign INT_SEQ   = r_int_seq;
   assign RESP      = r_resp;
   assign BRK6E     = T6 & r_int_seq;
   assign VEC       = (T5 | T6) ? r_vec_frz : w_vec_live;
   assign _ready    = _RES & ~RDY & ~WR;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed table-driven bench for timing_sequencer; NMI cases follow the
// TSEQ_NMI_EN build option.
module tb_timing_sequencer;

   typedef struct {
      logic [7:0]  in;   // {RDY, WR, TWOCYCLE, ENDX, BRK_OP, _IRQ, I_FLAG, _NMI}
      logic [14:0] exp;  // {T6..T0, SYNC, FORCE_BRK, INT_SEQ, RESP, BRK6E, VEC, _ready}
   } vec_t;

   localparam logic [7:0] N       = 8'b1000_0111;
   localparam logic [7:0] TW      = 8'b1010_0111;
   localparam logic [7:0] EX      = 8'b1001_0111;
   localparam logic [7:0] TWEX    = 8'b1011_0111;
   localparam logic [7:0] ST      = 8'b0000_0111;
   localparam logic [7:0] WRS     = 8'b0100_0111;
   localparam logic [7:0] WRE     = 8'b0101_0111;
   localparam logic [7:0] IRQ     = 8'b1000_0001;
   localparam logic [7:0] IRQ_EX  = 8'b1001_0001;
   localparam logic [7:0] IRQM    = 8'b1000_0011;
   localparam logic [7:0] IRQM_EX = 8'b1001_0011;
   localparam logic [7:0] BRK     = 8'b1000_1111;
   localparam logic [7:0] NMI0    = 8'b1000_0110;

   logic phi0 = 1'b0;
   logic res_n = 1'b1;
   logic rdy = 1'b1, wr = 1'b0, twocycle = 1'b0, endx = 1'b0, brk_op = 1'b0;
   logic irq_n = 1'b1, nmi_n = 1'b1, i_flag = 1'b1;
   logic t0, t1, t2, t3, t4, t5, t6;
   logic sync, force_brk, int_seq, resp, brk6e, ready_n;
   logic [1:0] vec;

   int total = 0;
   int bad = 0;
   vec_t tbl[$];

   timing_sequencer dut (
      .PHI0      (phi0),
      ._RES      (res_n),
      .RDY       (rdy),
      .WR        (wr),
      .TWOCYCLE  (twocycle),
      .ENDX      (endx),
      .BRK_OP    (brk_op),
      ._IRQ      (irq_n),
      ._NMI      (nmi_n),
      .I_FLAG    (i_flag),
      .T0        (t0),
      .T1        (t1),
      .T2        (t2),
      .T3        (t3),
      .T4        (t4),
      .T5        (t5),
      .T6        (t6),
      .SYNC      (sync),
      .FORCE_BRK (force_brk),
      .INT_SEQ   (int_seq),
      .RESP      (resp),
      .BRK6E     (brk6e),
      .VEC       (vec),
      ._ready    (ready_n)
   );

   always #5 phi0 = ~phi0;

   function automatic vec_t mk(input logic [7:0] in, input int st, input logic [5:0] o,
                               input logic [1:0] v);
      vec_t e;
      e.in  = in;
      e.exp = {7'(1 << st), o[5:1], v, o[0]};
      return e;
   endfunction

   function automatic logic [14:0] actual();
      return {t6, t5, t4, t3, t2, t1, t0, sync, force_brk, int_seq, resp, brk6e, vec, ready_n};
   endfunction

   task automatic check(input string name, input int idx, input logic [14:0] exp);
      logic [14:0] act;
      act = actual();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %b required %b", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] in);
      {rdy, wr, twocycle, endx, brk_op, irq_n, i_flag, nmi_n} = in;
   endtask

   task automatic run_tbl(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge phi0);
         drive(tbl[i].in);
         #1;
         check(name, i, tbl[i].exp);
      end
      tbl.delete();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rst_e;
      rst_e = mk(ST, 1, 6'b011100, 2'd2);

      // Reset held for three cycles; _ready must stay 0 even when RDY drops.
      #1 res_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge phi0);
         drive((i == 1) ? ST : N);
         #1;
         check("reset_hold", i, rst_e.exp);
      end
      @(posedge phi0);
      #1 res_n = 1'b1;

      // Reset sequence, short opcodes, stalls, IRQ, masked IRQ, BRK.
      tbl.push_back(mk(TWEX,    1, 6'b011100, 2'd2));
      tbl.push_back(mk(EX,      2, 6'b011100, 2'd2));
      tbl.push_back(mk(N,       3, 6'b011100, 2'd2));
      tbl.push_back(mk(N,       4, 6'b011100, 2'd2));
      tbl.push_back(mk(N,       5, 6'b011100, 2'd2));
      tbl.push_back(mk(N,       6, 6'b011110, 2'd2));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(TW,      1, 6'b100000, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       1, 6'b100000, 2'd0));
      tbl.push_back(mk(N,       2, 6'b000000, 2'd0));
      tbl.push_back(mk(EX,      3, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       1, 6'b100000, 2'd0));
      tbl.push_back(mk(ST,      2, 6'b000001, 2'd0));
      tbl.push_back(mk(ST,      2, 6'b000001, 2'd0));
      tbl.push_back(mk(ST,      2, 6'b000001, 2'd0));
      tbl.push_back(mk(N,       2, 6'b000000, 2'd0));
      tbl.push_back(mk(EX,      3, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       1, 6'b100000, 2'd0));
      tbl.push_back(mk(WRS,     2, 6'b000000, 2'd0));
      tbl.push_back(mk(WRE,     3, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQ,     1, 6'b100000, 2'd0));
      tbl.push_back(mk(IRQ_EX,  2, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQ,     0, 6'b000000, 2'd0));
      tbl.push_back(mk(TW,      1, 6'b011000, 2'd0));
      tbl.push_back(mk(EX,      2, 6'b011000, 2'd0));
      tbl.push_back(mk(EX,      3, 6'b011000, 2'd0));
      tbl.push_back(mk(N,       4, 6'b011000, 2'd0));
      tbl.push_back(mk(N,       5, 6'b011000, 2'd0));
      tbl.push_back(mk(N,       6, 6'b011010, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQM,    1, 6'b100000, 2'd0));
      tbl.push_back(mk(IRQM_EX, 2, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQM,    0, 6'b000000, 2'd0));
      tbl.push_back(mk(BRK,     1, 6'b100000, 2'd0));
      tbl.push_back(mk(N,       2, 6'b001000, 2'd0));
      tbl.push_back(mk(EX,      3, 6'b001000, 2'd0));
      tbl.push_back(mk(N,       4, 6'b001000, 2'd0));
      tbl.push_back(mk(N,       5, 6'b001000, 2'd0));
      tbl.push_back(mk(N,       6, 6'b001010, 2'd0));
      tbl.push_back(mk(N,       0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,       1, 6'b100000, 2'd0));
      run_tbl("main");

`ifdef TSEQ_NMI_EN
      // Edge in T3 hijacks an IRQ; edge in T5 is deferred; edge on the
      // clearing cycle keeps NMIP set.
      tbl.push_back(mk(EX,   2, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQ,  0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    1, 6'b011000, 2'd0));
      tbl.push_back(mk(N,    2, 6'b011000, 2'd0));
      tbl.push_back(mk(NMI0, 3, 6'b011000, 2'd0));
      tbl.push_back(mk(NMI0, 4, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    5, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    6, 6'b011010, 2'd1));
      tbl.push_back(mk(N,    0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    1, 6'b100000, 2'd0));
      tbl.push_back(mk(EX,   2, 6'b000000, 2'd0));
      tbl.push_back(mk(IRQ,  0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    1, 6'b011000, 2'd0));
      tbl.push_back(mk(N,    2, 6'b011000, 2'd0));
      tbl.push_back(mk(N,    3, 6'b011000, 2'd0));
      tbl.push_back(mk(N,    4, 6'b011000, 2'd0));
      tbl.push_back(mk(NMI0, 5, 6'b011000, 2'd0));
      tbl.push_back(mk(NMI0, 6, 6'b011010, 2'd0));
      tbl.push_back(mk(N,    0, 6'b000000, 2'd1));
      tbl.push_back(mk(N,    1, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    2, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    3, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    4, 6'b011000, 2'd1));
      tbl.push_back(mk(N,    5, 6'b011000, 2'd1));
      tbl.push_back(mk(NMI0, 6, 6'b011010, 2'd1));
      tbl.push_back(mk(N,    0, 6'b000000, 2'd1));
      tbl.push_back(mk(N,    1, 6'b011000, 2'd1));
      run_tbl("nmi");
`else
      // _NMI toggling is ignored when the latch is not built.
      tbl.push_back(mk(NMI0, 2, 6'b000000, 2'd0));
      tbl.push_back(mk(EX,   3, 6'b000000, 2'd0));
      tbl.push_back(mk(NMI0, 0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    1, 6'b100000, 2'd0));
      tbl.push_back(mk(NMI0, 2, 6'b000000, 2'd0));
      tbl.push_back(mk(EX,   3, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    0, 6'b000000, 2'd0));
      tbl.push_back(mk(N,    1, 6'b100000, 2'd0));
      run_tbl("no_nmi");
`endif

      // Reset asserted mid-instruction takes effect asynchronously.
      @(negedge phi0);
      drive(ST);
      #3 res_n = 1'b0;
      #1 check("reset_async", 0, rst_e.exp);
      @(negedge phi0);
      #1 check("reset_async", 1, rst_e.exp);
      @(posedge phi0);
      #1 res_n = 1'b1;
      tbl.push_back(mk(N, 1, 6'b011100, 2'd2));
      tbl.push_back(mk(N, 2, 6'b011100, 2'd2));
      tbl.push_back(mk(N, 3, 6'b011100, 2'd2));
      run_tbl("reset_seq_a");

      // Reset reasserted mid reset-sequence restarts at T1.
      @(negedge phi0);
      drive(N);
      #3 res_n = 1'b0;
      #1 check("reset_restart", 0, rst_e.exp);
      @(posedge phi0);
      #1 res_n = 1'b1;
      tbl.push_back(mk(N, 1, 6'b011100, 2'd2));
      tbl.push_back(mk(N, 2, 6'b011100, 2'd2));
      run_tbl("reset_seq_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
